// File: rtl/ap_ctrl_perf_monitor_if.sv
// Bundle of ap_ctrl_chain handshake and pipeline iteration strobes for
// NUM_CH channels. The master side drives them (the monitored design or a
// bench). The slave side observes them (the performance monitor).
interface ap_ctrl_perf_monitor_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] ap_start;
   logic [NUM_CH-1:0] ap_ready;
   logic [NUM_CH-1:0] ap_done;
   logic [NUM_CH-1:0] ap_continue;
   logic [NUM_CH-1:0] iter_start;
   logic [NUM_CH-1:0] iter_end;

   modport master (
      output ap_start, ap_ready, ap_done, ap_continue, iter_start, iter_end
   );

   modport slave (
      input  ap_start, ap_ready, ap_done, ap_continue, iter_start, iter_end
   );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel performance monitor for ap_ctrl_chain handshakes.
// - Counts starts, dones, busy cycles, stall cycles, iterations and the peak
//   number of iterations in flight.
// - Measures start-to-done latency with a timestamp FIFO.
// - Counters are read through an indexed register port with a one-cycle
//   return. The returned value is the value at the end of the request cycle.
// Optional build macro MON_SATURATE_EN: counters stop at all-ones instead of
// wrapping. Either way, ovf becomes sticky for that channel.
//
// state | meaning
// IDLE  | no transaction outstanding
// BUSY  | at least one accepted start not yet completed
// STALL | done asserted but held off by ap_continue=0
module ap_ctrl_perf_monitor #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int TS_W     = 32,
   parameter int INFLIGHT = 4
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic                                           enable,
   input  logic                                           clear,
   ap_ctrl_perf_monitor_if.slave                          mon,
   input  logic                                           rd_en,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
   input  logic [2:0]                                     rd_reg,
   output logic [CNT_W-1:0]                               rd_data,
   output logic                                           rd_valid,
   output logic [NUM_CH-1:0]                              ovf,
   output logic [NUM_CH-1:0]                              err
);
   localparam int          PW   = $clog2(INFLIGHT);
   localparam logic [PW:0] FULL = (PW+1)'(INFLIGHT);

   typedef enum logic [1:0] {IDLE, BUSY, STALL} state_t;

   state_t            state_q [NUM_CH];
   state_t            state_d [NUM_CH];
   logic [TS_W-1:0]   now;
   logic [TS_W-1:0]   fifo_q  [NUM_CH][INFLIGHT];
   logic [PW-1:0]     wp_q    [NUM_CH];
   logic [PW-1:0]     wp_d    [NUM_CH];
   logic [PW-1:0]     rp_q    [NUM_CH];
   logic [PW-1:0]     rp_d    [NUM_CH];
   logic [PW:0]       occ_q   [NUM_CH];
   logic [PW:0]       occ_d   [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH][6];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH][6];
   logic [TS_W-1:0]   lat_q   [NUM_CH][2];
   logic [TS_W-1:0]   lat_d   [NUM_CH][2];
   logic [CNT_W-1:0]  infl_q  [NUM_CH];
   logic [CNT_W-1:0]  infl_d  [NUM_CH];
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] ovf_d;
   logic [NUM_CH-1:0] err_d;
   logic [CNT_W-1:0]  rd_data_d;
   logic [NUM_CH-1:0] start_acc;
   logic [NUM_CH-1:0] done_acc;
   logic [NUM_CH-1:0] stall;

   assign start_acc = mon.ap_start & mon.ap_ready;
   assign done_acc  = mon.ap_done & mon.ap_continue;
   assign stall     = mon.ap_done & ~mon.ap_continue;

   // Returns {overflow, next value} for a counter increment.
   function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
`ifdef MON_SATURATE_EN
      if (&v) return {1'b1, v};
`else
      if (&v) return {1'b1, {CNT_W{1'b0}}};
`endif
      return {1'b0, v + CNT_W'(1)};
   endfunction

   // Next-state for the FIFO, the in-flight tracker, the counters and the sticky flags.
   always_comb begin
      logic [CNT_W:0]  b;
      logic [TS_W-1:0] lat_v;
      logic            lat_upd;
      logic [4:0]      inc;
      b       = '0;
      lat_v   = '0;
      lat_upd = 1'b0;
      inc     = '0;
      ovf_d   = ovf;
      err_d   = err;
      push    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wp_d[c]   = wp_q[c];
         rp_d[c]   = rp_q[c];
         occ_d[c]  = occ_q[c];
         infl_d[c] = infl_q[c];
         for (int k = 0; k < 6; k++) cnt_d[c][k] = cnt_q[c][k];
         lat_d[c][0] = lat_q[c][0];
         lat_d[c][1] = lat_q[c][1];
         lat_v       = '0;
         lat_upd     = 1'b0;

         if (start_acc[c] && done_acc[c]) begin
            // Empty FIFO means the start is completed in the same cycle (latency 0).
            lat_upd = 1'b1;
            if (occ_q[c] != '0) begin
               lat_v   = now - fifo_q[c][rp_q[c]];
               push[c] = 1'b1;
               wp_d[c] = wp_q[c] + PW'(1);
               rp_d[c] = rp_q[c] + PW'(1);
            end
         end else if (start_acc[c]) begin
            if (occ_q[c] == FULL) begin
               err_d[c] = 1'b1;
            end else begin
               push[c]  = 1'b1;
               wp_d[c]  = wp_q[c] + PW'(1);
               occ_d[c] = occ_q[c] + (PW+1)'(1);
            end
         end else if (done_acc[c]) begin
            if (occ_q[c] == '0) begin
               err_d[c] = 1'b1;
            end else begin
               lat_upd  = 1'b1;
               lat_v    = now - fifo_q[c][rp_q[c]];
               rp_d[c]  = rp_q[c] + PW'(1);
               occ_d[c] = occ_q[c] - (PW+1)'(1);
            end
         end

         if (mon.iter_start[c] && !mon.iter_end[c]) begin
            infl_d[c] = infl_q[c] + CNT_W'(1);
         end else if (mon.iter_end[c] && !mon.iter_start[c]) begin
            if (infl_q[c] == '0) err_d[c] = 1'b1;
            else                 infl_d[c] = infl_q[c] - CNT_W'(1);
         end

         if (enable) begin
            inc = {mon.iter_end[c], stall[c], state_q[c] != IDLE, done_acc[c], start_acc[c]};
            for (int k = 0; k < 5; k++) begin
               if (inc[k]) begin
                  b           = bump(cnt_q[c][k]);
                  cnt_d[c][k] = b[CNT_W-1:0];
                  if (b[CNT_W]) ovf_d[c] = 1'b1;
               end
            end
            if (infl_d[c] > cnt_q[c][5]) cnt_d[c][5] = infl_d[c];
            if (lat_upd) begin
               lat_d[c][0] = lat_v;
               if (lat_v > lat_q[c][1]) lat_d[c][1] = lat_v;
            end
         end

         if (clear) begin
            wp_d[c]   = '0;
            rp_d[c]   = '0;
            occ_d[c]  = '0;
            infl_d[c] = '0;
            for (int k = 0; k < 6; k++) cnt_d[c][k] = '0;
            lat_d[c][0] = '0;
            lat_d[c][1] = '0;
         end
      end
      if (clear) begin
         push  = '0;
         ovf_d = '0;
         err_d = '0;
      end
   end

   // Next-state logic for the channel FSM, using the occupancy after this cycle's push/pop.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         case (state_q[c])
            IDLE:    if (start_acc[c] && occ_d[c] != '0) state_d[c] = BUSY;
            BUSY:    if (done_acc[c])  state_d[c] = (occ_d[c] == '0) ? IDLE : BUSY;
                     else if (stall[c]) state_d[c] = STALL;
            STALL:   if (done_acc[c])  state_d[c] = (occ_d[c] == '0) ? IDLE : BUSY;
                     else if (!mon.ap_done[c]) state_d[c] = BUSY;
            default: state_d[c] = IDLE;
         endcase
         if (clear) state_d[c] = IDLE;
      end
   end

   // Read mux on next-state values, so the read returns the value at the end of the request cycle.
   always_comb begin
      rd_data_d = '0;
      if (rd_en && (int'(rd_ch) < NUM_CH)) begin
         case (rd_reg)
            3'd0: rd_data_d = cnt_d[rd_ch][0];
            3'd1: rd_data_d = cnt_d[rd_ch][1];
            3'd2: rd_data_d = cnt_d[rd_ch][2];
            3'd3: rd_data_d = cnt_d[rd_ch][3];
            3'd4: rd_data_d = cnt_d[rd_ch][4];
            3'd5: rd_data_d = cnt_d[rd_ch][5];
            3'd6: rd_data_d = CNT_W'(lat_d[rd_ch][0]);
            default: rd_data_d = CNT_W'(lat_d[rd_ch][1]);
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= '{default: IDLE};
      else        state_q <= state_d;
   end

   // Datapath registers, free-running timestamp and read port.
   always_ff @(posedge clock) begin
      if (!reset) begin
         now      <= '0;
         fifo_q   <= '{default: '{default: '0}};
         wp_q     <= '{default: '0};
         rp_q     <= '{default: '0};
         occ_q    <= '{default: '0};
         cnt_q    <= '{default: '{default: '0}};
         lat_q    <= '{default: '{default: '0}};
         infl_q   <= '{default: '0};
         ovf      <= '0;
         err      <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         now    <= now + TS_W'(1);
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         occ_q  <= occ_d;
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         infl_q <= infl_d;
         ovf    <= ovf_d;
         err    <= err_d;
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) fifo_q[c][wp_q[c]] <= now;
         end
         rd_data  <= rd_data_d;
         rd_valid <= rd_en;
      end
   end
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor.
// Instance A uses the default widths.
// Instance B uses 4-bit counters to exercise counter overflow.
module tb_ap_ctrl_perf_monitor;
   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       clear_a, clear_b;
   logic       rd_en, b_rd_en;
   logic [1:0] rd_ch, b_rd_ch;
   logic [2:0] rd_reg, b_rd_reg;
   logic [31:0] rd_data;
   logic [3:0]  b_rd_data;
   logic        rd_valid, b_rd_valid;
   logic [3:0]  ovf_a, err_a, ovf_b, err_b;
   int          n_checks = 0;
   int          n_errors = 0;

   ap_ctrl_perf_monitor_if #(.NUM_CH(4)) mon_a ();
   ap_ctrl_perf_monitor_if #(.NUM_CH(4)) mon_b ();

   ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .TS_W(32), .INFLIGHT(4)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear_a), .mon(mon_a),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_reg(rd_reg), .rd_data(rd_data),
      .rd_valid(rd_valid), .ovf(ovf_a), .err(err_a));

   ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(4), .TS_W(4), .INFLIGHT(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear_b), .mon(mon_b),
      .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_reg(b_rd_reg), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .ovf(ovf_b), .err(err_b));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd_a(input int ch, input int r, input logic [31:0] exp, input string tag);
      rd_en  = 1'b1;
      rd_ch  = ch[1:0];
      rd_reg = r[2:0];
      @(negedge clock);
      rd_en = 1'b0;
      check({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
      check(tag, rd_data, exp);
   endtask

   task automatic rd_b(input int ch, input int r, input logic [31:0] exp, input string tag);
      b_rd_en  = 1'b1;
      b_rd_ch  = ch[1:0];
      b_rd_reg = r[2:0];
      @(negedge clock);
      b_rd_en = 1'b0;
      check({tag, "_vld"}, {31'b0, b_rd_valid}, 32'd1);
      check(tag, {28'b0, b_rd_data}, exp);
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
      rd_en = 1'b0; rd_ch = '0; rd_reg = '0;
      b_rd_en = 1'b0; b_rd_ch = '0; b_rd_reg = '0;
      mon_a.ap_start = '0; mon_a.ap_ready = '0; mon_a.ap_done = '0;
      mon_a.ap_continue = '0; mon_a.iter_start = '0; mon_a.iter_end = '0;
      mon_b.ap_start = '0; mon_b.ap_ready = '0; mon_b.ap_done = '0;
      mon_b.ap_continue = '0; mon_b.iter_start = '0; mon_b.iter_end = '0;
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // Reset state
      check("rst_ovf", {28'b0, ovf_a}, 0);
      check("rst_err", {28'b0, err_a}, 0);
      check("rst_rdv", {31'b0, rd_valid}, 0);
      for (int r = 0; r < 8; r++) rd_a(0, r, 0, $sformatf("rst_reg%0d", r));
      @(negedge clock);
      check("rdv_pulse", {31'b0, rd_valid}, 0);

      // ch0: single transaction, three stall cycles, latency 8
      mon_a.ap_start[0] = 1'b1; mon_a.ap_ready[0] = 1'b1;
      @(negedge clock);
      mon_a.ap_start[0] = 1'b0; mon_a.ap_ready[0] = 1'b0;
      repeat (4) @(negedge clock);
      mon_a.ap_done[0] = 1'b1; mon_a.ap_continue[0] = 1'b0;
      repeat (3) @(negedge clock);
      mon_a.ap_continue[0] = 1'b1;
      @(negedge clock);
      mon_a.ap_done[0] = 1'b0; mon_a.ap_continue[0] = 1'b0;
      repeat (2) @(negedge clock);
      rd_a(0, 0, 1, "ch0_start");
      rd_a(0, 1, 1, "ch0_done");
      rd_a(0, 2, 8, "ch0_busy");
      rd_a(0, 3, 3, "ch0_stall");
      rd_a(0, 6, 8, "ch0_lastlat");
      rd_a(0, 7, 8, "ch0_maxlat");
      check("ch0_err", {28'b0, err_a}, 0);

      // ch1: five back-to-back starts overflow the 4-deep FIFO
      mon_a.ap_start[1] = 1'b1; mon_a.ap_ready[1] = 1'b1;
      repeat (5) @(negedge clock);
      mon_a.ap_start[1] = 1'b0; mon_a.ap_ready[1] = 1'b0;
      rd_a(1, 0, 5, "ch1_start");
      check("ch1_err", {28'b0, err_a}, 32'b0010);

      // ch2: start and done in the same cycle with an empty FIFO
      mon_a.ap_start[2] = 1'b1; mon_a.ap_ready[2] = 1'b1;
      mon_a.ap_done[2] = 1'b1;  mon_a.ap_continue[2] = 1'b1;
      @(negedge clock);
      mon_a.ap_start[2] = 1'b0; mon_a.ap_ready[2] = 1'b0;
      mon_a.ap_done[2] = 1'b0;  mon_a.ap_continue[2] = 1'b0;
      repeat (2) @(negedge clock);
      rd_a(2, 0, 1, "ch2_start");
      rd_a(2, 1, 1, "ch2_done");
      rd_a(2, 2, 0, "ch2_busy_idle");
      rd_a(2, 6, 0, "ch2_lastlat");
      check("ch2_err", {28'b0, err_a}, 32'b0010);

      // enable low freezes counters
      enable = 1'b0;
      mon_a.ap_start[2] = 1'b1; mon_a.ap_ready[2] = 1'b1;
      @(negedge clock);
      mon_a.ap_start[2] = 1'b0; mon_a.ap_ready[2] = 1'b0;
      enable = 1'b1;
      rd_a(2, 0, 1, "ch2_frozen");

      // ch3: iteration tracking and underflow
      mon_a.iter_start[3] = 1'b1;
      repeat (3) @(negedge clock);
      mon_a.iter_end[3] = 1'b1;
      @(negedge clock);
      mon_a.iter_start[3] = 1'b0;
      repeat (4) @(negedge clock);
      mon_a.iter_end[3] = 1'b0;
      rd_a(3, 4, 5, "ch3_iter");
      rd_a(3, 5, 3, "ch3_maxinf");
      check("ch3_err", {28'b0, err_a}, 32'b1010);

      // ch0: done with empty FIFO and no start
      mon_a.ap_done[0] = 1'b1; mon_a.ap_continue[0] = 1'b1;
      @(negedge clock);
      mon_a.ap_done[0] = 1'b0; mon_a.ap_continue[0] = 1'b0;
      rd_a(0, 1, 2, "ch0_done_orphan");
      rd_a(0, 6, 8, "ch0_lat_kept");
      check("ch0_orphan_err", {28'b0, err_a}, 32'b1011);
      check("a_ovf", {28'b0, ovf_a}, 0);

      // clear on A
      clear_a = 1'b1;
      @(negedge clock);
      clear_a = 1'b0;
      rd_a(1, 0, 0, "clr_ch1_start");
      rd_a(0, 7, 0, "clr_ch0_maxlat");
      rd_a(3, 5, 0, "clr_ch3_maxinf");
      check("clr_err", {28'b0, err_a}, 0);

      // B: 17 starts on 4-bit counters
      mon_b.ap_start[0] = 1'b1; mon_b.ap_ready[0] = 1'b1;
      repeat (17) @(negedge clock);
      mon_b.ap_start[0] = 1'b0; mon_b.ap_ready[0] = 1'b0;
`ifdef MON_SATURATE_EN
      rd_b(0, 0, 15, "b_start_sat");
`else
      rd_b(0, 0, 1, "b_start_wrap");
`endif
      check("b_ovf", {31'b0, ovf_b[0]}, 1);
      clear_b = 1'b1;
      @(negedge clock);
      clear_b = 1'b0;
      rd_b(0, 0, 0, "b_clr_start");
      check("b_clr_ovf", {28'b0, ovf_b}, 0);
      check("b_clr_err", {28'b0, err_b}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
